ring_phase_monitor: RTL

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

---
 rtl/ring_phase_pkg.sv | 33 +++
 rtl/onehot_encoder_8.sv | 31 +++
 rtl/ring_phase_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ring_phase_pkg.sv
// ---------------------------------------------------------------------------
// ring_phase_pkg
// Shared types and constants for the ring phase monitor:
//   - RING_WIDTH      : width of the upstream one-hot ring counter (8)
//   - phase_t         : binary ring index
//   - state_e         : monitor FSM states (IDLE, TRACK, FAULT)
//   - fault_code_e    : fault codes (none, not one-hot, illegal jump)
//   - next_phase()    : legal successor of a ring index (mod 8)
// ---------------------------------------------------------------------------
package ring_phase_pkg;

    localparam int RING_WIDTH = 8;

    typedef logic [2:0] phase_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE         = 2'b00,
        FC_NOT_ONEHOT   = 2'b01,
        FC_ILLEGAL_JUMP = 2'b10
    } fault_code_e;

    // 3-bit arithmetic wraps 7 -> 0, which is exactly the ring successor.
    function automatic phase_t next_phase(input phase_t p);
        return p + 3'd1;
    endfunction

endpackage

// File: rtl/onehot_encoder_8.sv
// ---------------------------------------------------------------------------
// onehot_encoder_8
// Combinational one-hot to binary index encoder for the 8-bit ring.
// Ports:
//   vec_in     [7:0] : sample from the ring counter
//   idx_out    [2:0] : binary index (meaningful only when onehot_out is 1)
//   onehot_out       : 1 when exactly one bit of vec_in is set
// ---------------------------------------------------------------------------
module onehot_encoder_8
    import ring_phase_pkg::*;
(
    input  logic [RING_WIDTH-1:0] vec_in,
    output phase_t                idx_out,
    output logic                  onehot_out
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned (that would infer a latch).
        idx_out = '0;
        for (int i = 0; i < RING_WIDTH; i++) begin
            if (vec_in[i]) begin
                idx_out = idx_out | phase_t'(i);
            end
        end
        // Non-zero with no second set bit: clearing the lowest set bit leaves 0.
        onehot_out = (vec_in != '0) &&
                     ((vec_in & (vec_in - RING_WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// ---------------------------------------------------------------------------
// ring_phase_monitor
// Watches an 8-bit one-hot ring counter, reports its phase, counts completed
// revolutions and flags illegal samples.
// Ports:
//   Clk_In, Reset_In (async, active-high)
//   Enable_In        : sample qualifier; low means Count_In is ignored
//   Clear_In         : synchronous clear of revolutions, fault, stall, state
//   Count_In   [7:0] : one-hot ring state
//   Phase_Out  [2:0] : index of last accepted sample
//   Valid_Out        : high while tracking
//   Rev_Count_Out    : completed revolutions (wraps)
//   Wrap_Pulse_Out   : one-cycle pulse on each 7 -> 0 advance
//   Fault_Out, Fault_Code_Out[1:0] : sticky fault and its cause
//   Stall_Out        : hold watchdog flag
// Build option: define RING_PHASE_MONITOR_STALL_CHECK_EN to include the stall
// watchdog; otherwise Stall_Out is constant 0.
// ---------------------------------------------------------------------------
module ring_phase_monitor
    import ring_phase_pkg::*;
#(
    parameter int REV_WIDTH   = 16,
    parameter int STALL_LIMIT = 32
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Clear_In,
    input  logic [RING_WIDTH-1:0] Count_In,
    output logic [2:0]            Phase_Out,
    output logic                  Valid_Out,
    output logic [REV_WIDTH-1:0]  Rev_Count_Out,
    output logic                  Wrap_Pulse_Out,
    output logic                  Fault_Out,
    output logic [1:0]            Fault_Code_Out,
    output logic                  Stall_Out
);

    phase_t      sample_idx;
    logic        sample_onehot;

    state_e      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        valid_q, valid_d;
    logic [REV_WIDTH-1:0] rev_q, rev_d;
    logic        wrap_q, wrap_d;
    logic        fault_q, fault_d;
    fault_code_e code_q, code_d;

    onehot_encoder_8 u_enc (
        .vec_in     (Count_In),
        .idx_out    (sample_idx),
        .onehot_out (sample_onehot)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rev_d   = rev_q;
        wrap_d  = 1'b0;
        fault_d = fault_q;
        code_d  = code_q;

        if (Clear_In) begin
            // Clear wins over any wrap/fault on the same edge; phase is kept.
            state_d = ST_IDLE;
            rev_d   = '0;
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end else if (Enable_In) begin
            case (state_q)
                ST_IDLE: begin
                    // Non-one-hot samples are ignored until the ring settles.
                    if (sample_onehot) begin
                        state_d = ST_TRACK;
                        phase_d = sample_idx;
                    end
                end
                ST_TRACK: begin
                    if (!sample_onehot) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        code_d  = FC_NOT_ONEHOT;
                    end else if (sample_idx == phase_q) begin
                        // Hold: legal, nothing moves.
                    end else if (sample_idx == next_phase(phase_q)) begin
                        phase_d = sample_idx;
                        if (phase_q == 3'd7) begin
                            wrap_d = 1'b1;
                            rev_d  = rev_q + REV_WIDTH'(1);
                        end
                    end else begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        code_d  = FC_ILLEGAL_JUMP;
                    end
                end
                default: begin
                    // FAULT is left only through Clear_In or reset.
                end
            endcase
        end
        valid_d = (state_d == ST_TRACK);
    end

    // NOTE: async reset covers every flop here; there is no storage array, so
    // nothing is left without a defined reset value.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            valid_q <= 1'b0;
            rev_q   <= '0;
            wrap_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            rev_q   <= rev_d;
            wrap_q  <= wrap_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

`ifdef RING_PHASE_MONITOR_STALL_CHECK_EN
    localparam int STALL_CW = $clog2(STALL_LIMIT + 1);

    logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;
    logic                stall_q, stall_d;
    logic                track_sample;
    logic                hold_evt;
    logic                adv_evt;

    assign track_sample = Enable_In && !Clear_In && (state_q == ST_TRACK) && sample_onehot;
    assign hold_evt     = track_sample && (sample_idx == phase_q);
    assign adv_evt      = track_sample && (sample_idx == next_phase(phase_q));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        if (Clear_In) begin
            stall_cnt_d = '0;
            stall_d     = 1'b0;
        end else if (hold_evt) begin
            // Count saturates at the limit; the flag rises on the limit-th hold.
            if (stall_cnt_q < STALL_CW'(STALL_LIMIT)) begin
                stall_cnt_d = stall_cnt_q + STALL_CW'(1);
            end
            if (stall_cnt_q >= STALL_CW'(STALL_LIMIT - 1)) begin
                stall_d = 1'b1;
            end
        end else if (adv_evt) begin
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign Stall_Out = stall_q;
`else
    assign Stall_Out = 1'b0;
`endif

    assign Phase_Out      = phase_q;
    assign Valid_Out      = valid_q;
    assign Rev_Count_Out  = rev_q;
    assign Wrap_Pulse_Out = wrap_q;
    assign Fault_Out      = fault_q;
    assign Fault_Code_Out = code_q;

endmodule
